vga_scan_ctrl: RTL and testbench
================================

# vga_scan_ctrl

Scan sequencer for the 720p VGA output path. It runs the raw horizontal/vertical counters and drives the frame-buffer read port with a pixel-doubled address (640x360 image upscaled to 1280x720). It delivers H_pos/V_pos/valid_video to the pixel generator delayed by the memory read latency, so they line up with the returned pixel data. It also starts and stops scan-out cleanly on frame boundaries.

## Interface
Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_TOTAL, 1650, pixels per line including front porch, sync and back porch
- V_ACTIVE, 720, visible lines
- V_TOTAL, 750, lines per frame
- SCALE_SHIFT, 1, log2 of the upscale factor in each axis
- MEM_LAT, 1, read latency from rd_addr to valid in_data (1..4)
- ADDR_W, 18, frame-buffer address width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock
- reset  in  1  asynchronous active-high reset
- enable  in  1  level request to scan out
- rd_addr  out  ADDR_W  frame-buffer read address
- rd_en  out  1  read strobe, high only for active pixels
- H_pos  out  32  horizontal position, aligned to in_data
- V_pos  out  32  vertical position, aligned to in_data
- valid_video  out  1  active-region flag, aligned to in_data
- frame_start  out  1  one-cycle pulse when H_pos=0 and V_pos=0
- busy  out  1  high while the FSM is not IDLE or the alignment pipe holds a valid stage

## Operation
- Raw counters:
  - h_cnt runs 0..H_TOTAL-1, then wraps to 0 and increments v_cnt.
  - v_cnt runs 0..V_TOTAL-1, then wraps to 0.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Address: rd_addr = line_base + (h_cnt>>SCALE_SHIFT).
  - line_base is an incrementally maintained register; no multiplier.
  - line_base advances by H_ACTIVE>>SCALE_SHIFT at the last pixel of every line where v_cnt[SCALE_SHIFT-1:0] is all ones and v_cnt<V_ACTIVE.
  - line_base clears to 0 at frame wrap.
  - Maximum address is 640*360-1=230399, which fits in ADDR_W.
- Outside the active region: rd_en=0 and rd_addr=0.
- FSM states:
  - IDLE: counters and line_base held at 0. Goes to RUN when enable=1.
  - RUN: counters advance every cycle. Goes to DRAIN when enable=0. At frame end, counters wrap to (0,0).
  - DRAIN: counters advance. Returns to RUN when enable=1, with no disturbance to the counters. Goes to IDLE on the last pixel of the frame (h=H_TOTAL-1, v=V_TOTAL-1).
- Alignment pipe:
  - MEM_LAT registered stages carry {h_cnt, v_cnt, active}.
  - The stage outputs drive H_pos, V_pos and valid_video.
  - In IDLE the pipe shifts in {0,0,0}.
- frame_start fires at the pipe output when that stage holds (0,0) and the FSM was in RUN or DRAIN when the stage entered the pipe.
- Sync pulses are not generated here; the pixel generator derives them from H_pos/V_pos.

## Timing
- Reset: all outputs are 0, the FSM is in IDLE and all pipe stages are 0. Reset mid-frame aborts immediately; there is no drain.
- enable rising in IDLE at cycle t:
  - RUN starts at t+1 with h_cnt=0; rd_en=1 and rd_addr=0 at t+1.
  - frame_start and valid_video first assert at t+1+MEM_LAT.
- rd_addr and rd_en reflect the current counters in the same cycle; both are registered outputs with no combinational path from enable.
- Alignment latency: H_pos, V_pos and valid_video equal the counter values from MEM_LAT cycles earlier.
- enable dropping mid-frame: the current frame completes in full, IDLE is entered after the last pixel, then busy falls MEM_LAT cycles later.
- enable toggling low then high within one frame: no visible effect and no extra frame_start.
- Line wrap and frame wrap in the same cycle: v_cnt and line_base both go to 0; the frame wrap takes priority over the line_base advance.

## Structure
- Shared package vga_pkg holds:
  - the 720p timing constants (H_ACTIVE, HFP_WIDTH, HSYNCH_WIDTH, etc.) and derived totals;
  - typedef scan_pos_t (h, v, active);
  - typedef enum scan_state_t {IDLE, RUN, DRAIN}.
- One sub-module, scan_align_pipe: a parameterised MEM_LAT-deep shift register of scan_pos_t with asynchronous reset.

## Test plan
- Reset, then enable=1: frame_start appears exactly 1+MEM_LAT cycles after enable; the first rd_addr sequence is 0,0,1,1,2,...
- Full frame: 1650*750=1,237,500 cycles between frame_start pulses; 921,600 cycles with valid_video=1; rd_en count equals the valid_video count.
- Address doubling: lines 0 and 1 both start at address 0, line 2 starts at 640; the last active pixel (1279,719) reads address 230399.
- enable=0 at pixel (500,300): scan continues to (1649,749), then enters IDLE; busy falls MEM_LAT cycles later; no further rd_en.
- Assert reset at (800,400): all outputs are 0 immediately (asynchronous); after release, nothing happens until enable rises.
- MEM_LAT=3 build: valid_video is high exactly 3 cycles after each rd_en and H_pos matches the h_cnt that issued that read.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 720p timing constants and scan types for the VGA output path.
package vga_pkg;

    localparam int unsigned H_ACTIVE     = 1280;
    localparam int unsigned HFP_WIDTH    = 110;
    localparam int unsigned HSYNCH_WIDTH = 40;
    localparam int unsigned HBP_WIDTH    = 220;
    localparam int unsigned H_TOTAL      = H_ACTIVE + HFP_WIDTH + HSYNCH_WIDTH + HBP_WIDTH;

    localparam int unsigned V_ACTIVE     = 720;
    localparam int unsigned VFP_WIDTH    = 5;
    localparam int unsigned VSYNCH_WIDTH = 5;
    localparam int unsigned VBP_WIDTH    = 20;
    localparam int unsigned V_TOTAL      = V_ACTIVE + VFP_WIDTH + VSYNCH_WIDTH + VBP_WIDTH;

    localparam int unsigned POS_W        = 16;

    typedef struct packed {
        logic [POS_W-1:0] h;
        logic [POS_W-1:0] v;
        logic             active;
    } scan_pos_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_align_pipe.sv
// Fixed-depth shift register that delays scan positions to match the frame-buffer read latency.
module scan_align_pipe
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  scan_pos_t din,
    output scan_pos_t dout
);

    scan_pos_t stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// Scan sequencer: raw H/V counters, pixel-doubled frame-buffer addressing and
// latency-aligned position outputs, with frame-boundary start/stop.
module vga_scan_ctrl #(
    parameter int unsigned H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int unsigned H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int unsigned V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int unsigned V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned MEM_LAT     = 1,
    parameter int unsigned ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic [31:0]       H_pos,
    output logic [31:0]       V_pos,
    output logic              valid_video,
    output logic              frame_start,
    output logic              busy
);

    import vga_pkg::*;

    localparam int unsigned LINE_STEP  = H_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned SCALE_MASK = (1 << SCALE_SHIFT) - 1;

    scan_state_t       state, state_nxt;
    logic [POS_W-1:0]  h_cnt, v_cnt, h_nxt, v_nxt;
    logic [ADDR_W-1:0] line_base, line_base_nxt, rd_addr_nxt;
    logic              rd_en_nxt, busy_nxt;
    logic              line_end, frame_end, base_adv;
    logic              run_in, sof_in;
    logic [MEM_LAT-1:0] run_pipe, sof_pipe, run_pipe_nxt, sof_pipe_nxt;
    scan_pos_t         pipe_in, pipe_out;

    assign line_end  = (h_cnt == POS_W'(H_TOTAL - 1));
    assign frame_end = line_end && (v_cnt == POS_W'(V_TOTAL - 1));
    assign base_adv  = line_end && ((32'(v_cnt) & SCALE_MASK) == SCALE_MASK)
                       && (v_cnt < POS_W'(V_ACTIVE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enable low at the last pixel ends scan-out right there, so the frame in
    // flight is always the last one and no extra frame is drained.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = frame_end ? IDLE : DRAIN;
            DRAIN:   begin
                if (enable)         state_nxt = RUN;
                else if (frame_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next counters/address are computed here so rd_en/rd_addr can be registered
    // yet still track the counters of the same cycle.
    always_comb begin
        h_nxt         = '0;
        v_nxt         = '0;
        line_base_nxt = '0;
        if (state != IDLE && !frame_end) begin
            if (line_end) begin
                v_nxt         = v_cnt + POS_W'(1);
                line_base_nxt = base_adv ? line_base + ADDR_W'(LINE_STEP) : line_base;
            end else begin
                h_nxt         = h_cnt + POS_W'(1);
                v_nxt         = v_cnt;
                line_base_nxt = line_base;
            end
        end

        rd_en_nxt   = (state_nxt != IDLE) && (h_nxt < POS_W'(H_ACTIVE))
                      && (v_nxt < POS_W'(V_ACTIVE));
        rd_addr_nxt = rd_en_nxt ? line_base_nxt + ADDR_W'(h_nxt >> SCALE_SHIFT) : '0;

        run_in       = (state != IDLE);
        sof_in       = run_in && (h_cnt == '0) && (v_cnt == '0);
        run_pipe_nxt = MEM_LAT'({run_pipe, run_in});
        sof_pipe_nxt = MEM_LAT'({sof_pipe, sof_in});
        busy_nxt     = (state_nxt != IDLE) || (|run_pipe_nxt);

        pipe_in.h      = h_cnt;
        pipe_in.v      = v_cnt;
        pipe_in.active = rd_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            line_base <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            run_pipe  <= '0;
            sof_pipe  <= '0;
            busy      <= 1'b0;
        end else begin
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            line_base <= line_base_nxt;
            rd_en     <= rd_en_nxt;
            rd_addr   <= rd_addr_nxt;
            run_pipe  <= run_pipe_nxt;
            sof_pipe  <= sof_pipe_nxt;
            busy      <= busy_nxt;
        end
    end

    scan_align_pipe #(
        .DEPTH (MEM_LAT)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    assign H_pos       = 32'(pipe_out.h);
    assign V_pos       = 32'(pipe_out.v);
    assign valid_video = pipe_out.active;
    assign frame_start = sof_pipe[MEM_LAT-1];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl on a reduced raster (8x6 active in 11x8) with a 3-cycle read latency.
module tb_vga_scan_ctrl;

    localparam int HA    = 8;
    localparam int HT    = 11;
    localparam int VA    = 6;
    localparam int VT    = 8;
    localparam int SS    = 1;
    localparam int ML    = 3;
    localparam int AW    = 18;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [31:0]   H_pos, V_pos;
    logic          valid_video, frame_start, busy;

    vga_scan_ctrl #(
        .H_ACTIVE    (HA),
        .H_TOTAL     (HT),
        .V_ACTIVE    (VA),
        .V_TOTAL     (VT),
        .SCALE_SHIFT (SS),
        .MEM_LAT     (ML),
        .ADDR_W      (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .H_pos       (H_pos),
        .V_pos       (V_pos),
        .valid_video (valid_video),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got != exp) $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        else n_pass++;
    endtask

    // Reference model: an absolute pixel index since scan start, decoded with div/mod.
    typedef struct {
        int h;
        int v;
        bit act;
        bit run;
    } ent_t;

    bit   m_run;
    int   m_k;
    ent_t hist [ML+1];

    task automatic model_reset();
        m_run = 0;
        m_k   = 0;
        for (int i = 0; i <= ML; i++) hist[i] = '{0, 0, 0, 0};
    endtask

    task automatic model_step();
        ent_t e;
        if (!m_run) begin
            if (enable) begin
                m_run = 1;
                m_k   = 0;
            end
        end else if ((m_k % FRAME) == FRAME - 1 && !enable) begin
            m_run = 0;
            m_k   = 0;
        end else begin
            m_k++;
        end
        for (int i = ML; i > 0; i--) hist[i] = hist[i-1];
        e.run = m_run;
        e.h   = m_run ? (m_k % HT) : 0;
        e.v   = m_run ? ((m_k / HT) % VT) : 0;
        e.act = m_run && e.h < HA && e.v < VA;
        hist[0] = e;
    endtask

    task automatic check_model();
        int exp_addr;
        bit exp_busy;
        exp_addr = hist[0].act ? ((hist[0].v >> SS) * (HA >> SS) + (hist[0].h >> SS)) : 0;
        exp_busy = 0;
        for (int i = 0; i <= ML; i++) exp_busy |= hist[i].run;
        chk("rd_en", rd_en, hist[0].act);
        chk("rd_addr", rd_addr, exp_addr);
        chk("H_pos", H_pos, hist[ML].h);
        chk("V_pos", V_pos, hist[ML].v);
        chk("valid_video", valid_video, hist[ML].act);
        chk("frame_start", frame_start, hist[ML].run && hist[ML].h == 0 && hist[ML].v == 0);
        chk("busy", busy, exp_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit en;
        bit rd_en;
        int addr;
        bit valid;
        bit fs;
        int hpos;
        bit busy;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   fs_t [$];
        int   nvalid, nrden, maxaddr, w, n, nfs, idle_bad;

        vecs[0]  = '{1, 1, 0, 0, 0, 0, 1};
        vecs[1]  = '{1, 1, 0, 0, 0, 0, 1};
        vecs[2]  = '{1, 1, 1, 0, 0, 0, 1};
        vecs[3]  = '{1, 1, 1, 1, 1, 0, 1};
        vecs[4]  = '{1, 1, 2, 1, 0, 1, 1};
        vecs[5]  = '{1, 1, 2, 1, 0, 2, 1};
        vecs[6]  = '{1, 1, 3, 1, 0, 3, 1};
        vecs[7]  = '{1, 1, 3, 1, 0, 4, 1};
        vecs[8]  = '{1, 0, 0, 1, 0, 5, 1};
        vecs[9]  = '{1, 0, 0, 1, 0, 6, 1};
        vecs[10] = '{1, 0, 0, 1, 0, 7, 1};
        vecs[11] = '{1, 1, 0, 0, 0, 8, 1};

        reset  = 1'b1;
        enable = 1'b0;
        model_reset();

        // Reset state, then start-up sequence from the vector table
        do_reset();
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_valid", valid_video, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_hpos", H_pos, 0);
        chk("rst_busy", busy, 0);
        for (int i = 0; i < 12; i++) begin
            enable = vecs[i].en;
            tick();
            chk($sformatf("vec%0d_rd_en", i), rd_en, vecs[i].rd_en);
            chk($sformatf("vec%0d_rd_addr", i), rd_addr, vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), valid_video, vecs[i].valid);
            chk($sformatf("vec%0d_fs", i), frame_start, vecs[i].fs);
            chk($sformatf("vec%0d_hpos", i), H_pos, vecs[i].hpos);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
        end

        // Three continuous frames: pulse spacing, per-frame counts, top address
        do_reset();
        enable  = 1'b1;
        nvalid  = 0;
        nrden   = 0;
        maxaddr = 0;
        for (int e = 1; e <= 3 * FRAME; e++) begin
            tick();
            if (frame_start) fs_t.push_back(e);
            if (fs_t.size() == 1) begin
                nvalid += int'(valid_video);
                nrden  += int'(rd_en);
            end
            if (rd_en && int'(rd_addr) > maxaddr) maxaddr = int'(rd_addr);
        end
        chk("fs_count", fs_t.size(), 3);
        if (fs_t.size() >= 3) begin
            chk("first_fs_edge", fs_t[0], 1 + ML);
            chk("fs_gap1", fs_t[1] - fs_t[0], FRAME);
            chk("fs_gap2", fs_t[2] - fs_t[1], FRAME);
        end
        chk("valid_per_frame", nvalid, HA * VA);
        chk("rden_per_frame", nrden, HA * VA);
        chk("max_addr", maxaddr, (HA >> SS) * (VA >> SS) - 1);

        // Drop enable just after a frame start; scan must finish that frame only
        w = 0;
        while (!frame_start && w < 2 * FRAME) begin
            tick();
            w++;
        end
        chk("drain_sync_fs", frame_start, 1);
        enable = 1'b0;
        n   = 0;
        nfs = 0;
        while (busy && n < 3 * FRAME) begin
            tick();
            n++;
            if (frame_start) nfs++;
        end
        chk("busy_fall_edges", n, FRAME);
        chk("drain_extra_fs", nfs, 0);
        idle_bad = 0;
        repeat (20) begin
            tick();
            if (rd_en || busy || valid_video || frame_start) idle_bad++;
        end
        chk("idle_after_drain", idle_bad, 0);

        // Asynchronous reset mid-frame clears outputs without a clock edge
        do_reset();
        enable = 1'b1;
        repeat (40) tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_rd_en", rd_en, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_rd_en", rd_en, 0);
        chk("arst_rd_addr", rd_addr, 0);
        chk("arst_hpos", H_pos, 0);
        chk("arst_vpos", V_pos, 0);
        chk("arst_valid", valid_video, 0);
        chk("arst_fs", frame_start, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b0;
        model_reset();
        idle_bad = 0;
        repeat (30) begin
            tick();
            if (rd_en || busy || valid_video || frame_start || rd_addr != '0) idle_bad++;
        end
        chk("post_rst_quiet", idle_bad, 0);

        // Randomised enable toggling against the reference model
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            tick();
            check_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
